rs_issue_ctrl: RTL and testbench
================================

Name: rs_issue_ctrl

Overview:
Issue stage directly downstream of the reservation-station FIFO. Takes the FIFO head entry, pops it, and holds it in a single operand-capture slot. It snoops two common-data-bus (CDB) ports to fill any missing source operands, then issues the complete instruction to one functional unit over a valid/ready handshake. It also squashes its held entry on a branch flush by sequence tag.

Parameters:
ENTRY_WIDTH, 144, width of an RS entry. Field layout:
- [143] valid
- [142:111] seq tag
- [110:105] opcode
- [104] rdy_a, [103:72] val_a
- [71] rdy_b, [70:39] val_b
- [38:33] dest tag
- [32:0] aux
TAG_WIDTH, 6, producer/destination tag width. When rdy_x=0, val_x[TAG_WIDTH-1:0] holds the producer tag.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rs_empty  input  1  RS FIFO empty flag
rs_head  input  ENTRY_WIDTH  RS head entry (zero when empty)
rs_pop  output  1  one-cycle pop pulse to RS read side
cdb0_valid, cdb1_valid  input  1  CDB broadcast valid
cdb0_tag, cdb1_tag  input  TAG_WIDTH  CDB producer tag
cdb0_data, cdb1_data  input  32  CDB result value
branch  input  1  branch-mispredict flush, single-cycle level
branch_tag  input  32  flush boundary; entries with seq tag >= branch_tag are squashed
fu_valid  output  1  issue request to functional unit
fu_ready  input  1  functional unit accepts
fu_opcode  output  6  opcode of issued instruction
fu_op_a, fu_op_b  output  32  resolved operands
fu_dest  output  TAG_WIDTH  destination tag
fu_aux  output  33  aux field
busy  output  1  capture slot occupied

Behaviour:
- Reset (rst_n=0, async): state IDLE, slot cleared; rs_pop=0, fu_valid=0, busy=0; all fu_* data outputs = 0.
- FSM states: IDLE, WAIT, ISSUE.
- IDLE:
  - If !rs_empty and rs_head[143]=1 and head not flushed this cycle: latch head into slot, assert rs_pop for exactly this cycle, go to WAIT.
  - An invalid head (bit 143=0) is popped and discarded; stay IDLE.
- Capture-cycle CDB bypass: if cdb tag matches a not-ready operand's producer tag in the latch cycle, the latched operand is the CDB data with rdy set.
- WAIT:
  - Each cycle, for each operand with rdy=0, compare val[TAG_WIDTH-1:0] with cdb0_tag/cdb1_tag under valid.
  - On a match, load the data and set rdy. If both ports match the same tag, cdb0 wins.
  - When rdy_a and rdy_b are both 1 (registered), go to ISSUE.
- ISSUE:
  - fu_valid=1 with stable fu_* outputs until a cycle with fu_ready=1.
  - On that cycle: transfer completes, slot cleared, next state IDLE. No new capture in the same cycle; one bubble.
- Flush:
  - branch=1 with slot seq tag >= branch_tag (unsigned) in WAIT or ISSUE: slot cleared, fu_valid drops next cycle, state IDLE.
  - Flush wins over fu_ready in the same cycle; the FU must not count it as accepted.
  - branch=1 in IDLE: an incoming head with tag >= branch_tag is not popped this cycle. The RS performs its own flush.
  - An older entry (tag < branch_tag) is unaffected.
- rs_pop is never asserted when rs_empty=1 or busy=1.
- busy=1 in WAIT and ISSUE.
- Latency: head present at cycle N with both operands ready gives rs_pop at N and fu_valid at N+2 (N+1 with the optional feature).
- Reset mid-ISSUE: fu_valid falls immediately (async); the entry is lost.

Optional Feature:
- Macro ISSUE_FAST_PATH_EN.
- Defined: in IDLE, if the captured entry (after CDB bypass) has both operands ready, go directly to ISSUE, so fu_valid asserts the cycle after rs_pop.
- Undefined: every capture passes through WAIT for at least one cycle.

Test Plan:
1. Head tag=5, rdy_a=rdy_b=1, val_a=0x10, val_b=0x20, fu_ready=1 -> rs_pop one cycle; fu_valid at N+2 (N+1 with macro); fu_op_a=0x10, fu_op_b=0x20; busy falls after accept.
2. Head rdy_a=0, producer tag 0x07; cdb1 broadcasts tag 0x07, data 0xDEAD at N+3 -> fu_valid at N+4 with fu_op_a=0xDEAD.
3. Both CDBs broadcast tag 0x03 (data 0x1, 0x2) for waiting operand b -> fu_op_b=0x1.
4. In ISSUE with seq tag 9 and fu_ready=0: branch=1, branch_tag=8 -> fu_valid=0 next cycle, state IDLE. Repeat with branch_tag=10 -> entry still issues.
5. rs_empty=1 for 10 cycles -> rs_pop=0, fu_valid=0 throughout. Then invalid head (bit143=0) -> popped, no issue.
6. Assert rst_n=0 mid-ISSUE -> fu_valid, busy, rs_pop all 0 immediately. Release -> IDLE, next head captured normally.

Source files
------------

// File: rtl/rs_issue_ctrl.sv
// Issue slot after the RS FIFO: captures head, snoops CDB0/CDB1, issues to one FU; ISSUE_FAST_PATH_EN skips WAIT.
// Latency: rs_pop at N, fu_valid at N+2 (N+1 with ISSUE_FAST_PATH_EN) when operands are ready at capture.
// Backpressure: fu_* held stable until fu_ready; no pop while the slot is busy; branch flush squashes by seq tag.
module rs_issue_ctrl #(
    parameter int ENTRY_WIDTH = 144,
    parameter int TAG_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rs_empty,
    input  logic [ENTRY_WIDTH-1:0] rs_head,
    output logic                   rs_pop,
    input  logic                   cdb0_valid,
    input  logic [TAG_WIDTH-1:0]   cdb0_tag,
    input  logic [31:0]            cdb0_data,
    input  logic                   cdb1_valid,
    input  logic [TAG_WIDTH-1:0]   cdb1_tag,
    input  logic [31:0]            cdb1_data,
    input  logic                   branch,
    input  logic [31:0]            branch_tag,
    output logic                   fu_valid,
    input  logic                   fu_ready,
    output logic [5:0]             fu_opcode,
    output logic [31:0]            fu_op_a,
    output logic [31:0]            fu_op_b,
    output logic [TAG_WIDTH-1:0]   fu_dest,
    output logic [32:0]            fu_aux,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    state_t state, state_nxt;

    logic                 s_rdy_a, s_rdy_b;
    logic [31:0]          s_seq, s_val_a, s_val_b;
    logic [5:0]           s_opc;
    logic [TAG_WIDTH-1:0] s_dest;
    logic [32:0]          s_aux;

    logic                 h_vld, h_rdy_a, h_rdy_b;
    logic [31:0]          h_seq, h_val_a, h_val_b;
    logic [5:0]           h_opc;
    logic [TAG_WIDTH-1:0] h_dest;
    logic [32:0]          h_aux;

    logic        src_rdy_a, src_rdy_b, res_rdy_a, res_rdy_b;
    logic [31:0] src_val_a, src_val_b, res_val_a, res_val_b;
    logic        head_flush, slot_flush, take, clr;

    assign h_vld   = rs_head[143];
    assign h_seq   = rs_head[142:111];
    assign h_opc   = rs_head[110:105];
    assign h_rdy_a = rs_head[104];
    assign h_val_a = rs_head[103:72];
    assign h_rdy_b = rs_head[71];
    assign h_val_b = rs_head[70:39];
    assign h_dest  = rs_head[33 +: TAG_WIDTH];
    assign h_aux   = rs_head[32:0];

    // A not-ready operand carries its producer tag in the low bits; cdb0 has priority.
    function automatic logic [32:0] snoop(
        input logic                 rdy,
        input logic [31:0]          val,
        input logic                 c0v,
        input logic [TAG_WIDTH-1:0] c0t,
        input logic [31:0]          c0d,
        input logic                 c1v,
        input logic [TAG_WIDTH-1:0] c1t,
        input logic [31:0]          c1d
    );
        snoop = {rdy, val};
        if (!rdy) begin
            if (c0v && (c0t == val[TAG_WIDTH-1:0]))
                snoop = {1'b1, c0d};
            else if (c1v && (c1t == val[TAG_WIDTH-1:0]))
                snoop = {1'b1, c1d};
        end
    endfunction

    // The same snoop path serves the capture-cycle bypass (IDLE) and the WAIT update.
    assign src_rdy_a = (state == IDLE) ? h_rdy_a : s_rdy_a;
    assign src_val_a = (state == IDLE) ? h_val_a : s_val_a;
    assign src_rdy_b = (state == IDLE) ? h_rdy_b : s_rdy_b;
    assign src_val_b = (state == IDLE) ? h_val_b : s_val_b;

    assign {res_rdy_a, res_val_a} = snoop(src_rdy_a, src_val_a, cdb0_valid, cdb0_tag, cdb0_data,
                                          cdb1_valid, cdb1_tag, cdb1_data);
    assign {res_rdy_b, res_val_b} = snoop(src_rdy_b, src_val_b, cdb0_valid, cdb0_tag, cdb0_data,
                                          cdb1_valid, cdb1_tag, cdb1_data);

    assign head_flush = branch && (h_seq >= branch_tag);
    assign slot_flush = branch && (s_seq >= branch_tag);
    assign take       = (state == IDLE) && !rs_empty && h_vld && !head_flush;

    always_comb begin
        state_nxt = state;
        rs_pop    = 1'b0;
        case (state)
            IDLE: begin
                // Invalid heads are drained; young valid heads wait for the RS to flush them.
                rs_pop = rst_n && !rs_empty && (!h_vld || !head_flush);
                if (take) begin
`ifdef ISSUE_FAST_PATH_EN
                    state_nxt = (res_rdy_a && res_rdy_b) ? ISSUE : WAIT;
`else
                    state_nxt = WAIT;
`endif
                end
            end
            WAIT: begin
                if (slot_flush)
                    state_nxt = IDLE;
                else if (res_rdy_a && res_rdy_b)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (slot_flush || fu_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    assign clr = (state != IDLE) && (state_nxt == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seq   <= '0;
            s_opc   <= '0;
            s_rdy_a <= 1'b0;
            s_val_a <= '0;
            s_rdy_b <= 1'b0;
            s_val_b <= '0;
            s_dest  <= '0;
            s_aux   <= '0;
        end else if (take) begin
            s_seq   <= h_seq;
            s_opc   <= h_opc;
            s_rdy_a <= res_rdy_a;
            s_val_a <= res_val_a;
            s_rdy_b <= res_rdy_b;
            s_val_b <= res_val_b;
            s_dest  <= h_dest;
            s_aux   <= h_aux;
        end else if (clr) begin
            s_seq   <= '0;
            s_opc   <= '0;
            s_rdy_a <= 1'b0;
            s_val_a <= '0;
            s_rdy_b <= 1'b0;
            s_val_b <= '0;
            s_dest  <= '0;
            s_aux   <= '0;
        end else if (state == WAIT) begin
            s_rdy_a <= res_rdy_a;
            s_val_a <= res_val_a;
            s_rdy_b <= res_rdy_b;
            s_val_b <= res_val_b;
        end
    end

    // Data outputs read zero unless an issue request is being presented.
    assign fu_valid  = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign fu_opcode = fu_valid ? s_opc   : '0;
    assign fu_op_a   = fu_valid ? s_val_a : '0;
    assign fu_op_b   = fu_valid ? s_val_b : '0;
    assign fu_dest   = fu_valid ? s_dest  : '0;
    assign fu_aux    = fu_valid ? s_aux   : '0;

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Directed bench for rs_issue_ctrl: entry-level reference model compared every negedge plus literal spot checks.
module tb_rs_issue_ctrl;

`ifdef ISSUE_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rs_empty;
    logic [143:0] rs_head;
    logic         rs_pop;
    logic         cdb0_valid, cdb1_valid;
    logic [5:0]   cdb0_tag, cdb1_tag;
    logic [31:0]  cdb0_data, cdb1_data;
    logic         branch;
    logic [31:0]  branch_tag;
    logic         fu_valid, fu_ready;
    logic [5:0]   fu_opcode;
    logic [31:0]  fu_op_a, fu_op_b;
    logic [5:0]   fu_dest;
    logic [32:0]  fu_aux;
    logic         busy;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    rs_issue_ctrl #(.ENTRY_WIDTH(144), .TAG_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .rs_empty(rs_empty), .rs_head(rs_head), .rs_pop(rs_pop),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .branch(branch), .branch_tag(branch_tag),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_opcode(fu_opcode),
        .fu_op_a(fu_op_a), .fu_op_b(fu_op_b), .fu_dest(fu_dest), .fu_aux(fu_aux),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [143:0] mk(input logic v, input logic [31:0] seq, input logic [5:0] opc,
                                        input logic ra, input logic [31:0] va,
                                        input logic rb, input logic [31:0] vb,
                                        input logic [5:0] dest, input logic [32:0] aux);
        return {v, seq, opc, ra, va, rb, vb, dest, aux};
    endfunction

    // Reference model: one held instruction, its operand values, and whether it is being offered.
    bit          m_have, m_issue;
    logic [31:0] m_seq, m_a, m_b;
    logic        m_a_rdy, m_b_rdy;
    logic [5:0]  m_opc, m_dest;
    logic [32:0] m_aux;
    int          accepts = 0;

    function automatic logic [32:0] snp(input logic rdy, input logic [31:0] v);
        if (rdy) return {1'b1, v};
        if (cdb0_valid && cdb0_tag == v[5:0]) return {1'b1, cdb0_data};
        if (cdb1_valid && cdb1_tag == v[5:0]) return {1'b1, cdb1_data};
        return {1'b0, v};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [32:0] ra, rb;
        if (!rst_n) begin
            m_have  <= 1'b0;
            m_issue <= 1'b0;
        end else if (!m_have) begin
            if (!rs_empty && rs_head[143] && !(branch && rs_head[142:111] >= branch_tag)) begin
                ra = snp(rs_head[104], rs_head[103:72]);
                rb = snp(rs_head[71], rs_head[70:39]);
                m_have  <= 1'b1;
                m_issue <= FAST && ra[32] && rb[32];
                m_seq   <= rs_head[142:111];
                m_opc   <= rs_head[110:105];
                {m_a_rdy, m_a} <= ra;
                {m_b_rdy, m_b} <= rb;
                m_dest  <= rs_head[38:33];
                m_aux   <= rs_head[32:0];
            end
        end else if (branch && m_seq >= branch_tag) begin
            m_have  <= 1'b0;
            m_issue <= 1'b0;
        end else if (m_issue) begin
            if (fu_ready) begin
                m_have  <= 1'b0;
                m_issue <= 1'b0;
                accepts <= accepts + 1;
            end
        end else begin
            ra = snp(m_a_rdy, m_a);
            rb = snp(m_b_rdy, m_b);
            {m_a_rdy, m_a} <= ra;
            {m_b_rdy, m_b} <= rb;
            if (ra[32] && rb[32]) m_issue <= 1'b1;
        end
    end

    always @(negedge clk) begin : compare
        logic ev, ep;
        if (started) begin
            ev = m_have && m_issue;
            ep = rst_n && !m_have && !rs_empty &&
                 (!rs_head[143] || !(branch && rs_head[142:111] >= branch_tag));
            chk("rs_pop", rs_pop, ep);
            chk("fu_valid", fu_valid, ev);
            chk("busy", busy, m_have);
            chk("fu_opcode", fu_opcode, ev ? m_opc : 6'd0);
            chk("fu_op_a", fu_op_a, ev ? m_a : 32'd0);
            chk("fu_op_b", fu_op_b, ev ? m_b : 32'd0);
            chk("fu_dest", fu_dest, ev ? m_dest : 6'd0);
            chk("fu_aux", fu_aux, ev ? m_aux : 33'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a head for one cycle (the pop cycle), then withdraw it; returns cycles until fu_valid.
    task automatic push_and_wait(input logic [143:0] h, output int lat);
        rs_empty = 1'b0;
        rs_head  = h;
        #1;
        chk("pop_on_capture", rs_pop, 1'b1);
        tick();
        rs_empty = 1'b1;
        rs_head  = '0;
        lat = 1;
        while (!fu_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        rst_n = 1'b0; rs_empty = 1'b1; rs_head = '0;
        cdb0_valid = 1'b0; cdb0_tag = '0; cdb0_data = '0;
        cdb1_valid = 1'b0; cdb1_tag = '0; cdb1_data = '0;
        branch = 1'b0; branch_tag = '0; fu_ready = 1'b0;
        #2 started = 1'b1;
        repeat (3) tick();
        chk("reset_fu_valid", fu_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_op_a", fu_op_a, 32'd0);
        rst_n = 1'b1;

        // 1: both operands ready at capture
        fu_ready = 1'b1;
        push_and_wait(mk(1, 5, 6'h11, 1, 32'h10, 1, 32'h20, 6'h2A, 33'h1_2345_6789), lat);
        chk("t1_latency", lat, FAST ? 1 : 2);
        chk("t1_op_a", fu_op_a, 32'h10);
        chk("t1_op_b", fu_op_b, 32'h20);
        chk("t1_dest", fu_dest, 6'h2A);
        chk("t1_aux", fu_aux, 33'h1_2345_6789);
        tick();
        chk("t1_busy_after", busy, 1'b0);

        // 2: operand a waits for tag 7 on cdb1 at N+3
        rs_empty = 1'b0;
        rs_head  = mk(1, 6, 6'h02, 0, 32'h7, 1, 32'h55, 6'h01, 33'h0);
        #1 chk("t2_pop", rs_pop, 1'b1);
        tick(); rs_empty = 1'b1; rs_head = '0;
        tick();
        tick();
        cdb1_valid = 1'b1; cdb1_tag = 6'h07; cdb1_data = 32'hDEAD;
        #1 chk("t2_no_valid_n3", fu_valid, 1'b0);
        tick(); cdb1_valid = 1'b0;
        chk("t2_valid_n4", fu_valid, 1'b1);
        chk("t2_op_a", fu_op_a, 32'hDEAD);
        tick();

        // 3: both CDBs hit operand b's tag; cdb0 must win
        rs_empty = 1'b0;
        rs_head  = mk(1, 7, 6'h03, 1, 32'h77, 0, 32'h3, 6'h02, 33'h5);
        tick(); rs_empty = 1'b1; rs_head = '0;
        cdb0_valid = 1'b1; cdb0_tag = 6'h03; cdb0_data = 32'h1;
        cdb1_valid = 1'b1; cdb1_tag = 6'h03; cdb1_data = 32'h2;
        tick(); cdb0_valid = 1'b0; cdb1_valid = 1'b0;
        chk("t3_valid", fu_valid, 1'b1);
        chk("t3_op_b", fu_op_b, 32'h1);
        tick();

        // 4a: flush in ISSUE (tag 9 >= 8), fu_ready asserted alongside must not complete it
        fu_ready = 1'b0;
        push_and_wait(mk(1, 9, 6'h04, 1, 32'hA, 1, 32'hB, 6'h03, 33'h0), lat);
        tick();
        chk("t4_hold_valid", fu_valid, 1'b1);
        branch = 1'b1; branch_tag = 32'd8; fu_ready = 1'b1;
        tick(); branch = 1'b0; fu_ready = 1'b0;
        chk("t4_flushed_valid", fu_valid, 1'b0);
        chk("t4_flushed_busy", busy, 1'b0);
        // 4b: older entry survives a flush with boundary 10
        push_and_wait(mk(1, 9, 6'h04, 1, 32'hA, 1, 32'hB, 6'h03, 33'h0), lat);
        branch = 1'b1; branch_tag = 32'd10;
        tick(); branch = 1'b0;
        chk("t4_survive_valid", fu_valid, 1'b1);
        chk("t4_survive_op_a", fu_op_a, 32'hA);
        fu_ready = 1'b1;
        tick();
        chk("t4_accept_busy", busy, 1'b0);
        // 4c: head with seq == branch_tag is squashed in IDLE, not popped
        rs_empty = 1'b0; rs_head = mk(1, 10, 6'h05, 1, 32'h1, 1, 32'h2, 6'h04, 33'h0);
        branch = 1'b1; branch_tag = 32'd10;
        #1 chk("t4_head_squash_pop", rs_pop, 1'b0);
        tick(); branch = 1'b0; rs_empty = 1'b1; rs_head = '0;
        chk("t4_head_squash_busy", busy, 1'b0);

        // 5: empty FIFO idles, then an invalid head is drained without issue
        for (int i = 0; i < 10; i++) tick();
        chk("t5_idle_pop", rs_pop, 1'b0);
        rs_empty = 1'b0; rs_head = mk(0, 3, 6'h06, 1, 32'h9, 1, 32'h9, 6'h05, 33'h0);
        #1 chk("t5_invalid_pop", rs_pop, 1'b1);
        tick(); rs_empty = 1'b1; rs_head = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_invalid_no_issue", fu_valid, 1'b0);

        // 6: async reset while issuing, then normal capture
        fu_ready = 1'b0;
        push_and_wait(mk(1, 20, 6'h07, 1, 32'h44, 1, 32'h45, 6'h06, 33'h0), lat);
        rs_empty = 1'b0; rs_head = mk(1, 21, 6'h08, 1, 32'h66, 1, 32'h67, 6'h07, 33'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", fu_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_pop", rs_pop, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        fu_ready = 1'b1;
        push_and_wait(mk(1, 21, 6'h08, 1, 32'h66, 1, 32'h67, 6'h07, 33'h0), lat);
        chk("t6_after_latency", lat, FAST ? 1 : 2);
        chk("t6_after_op_a", fu_op_a, 32'h66);
        tick(); tick();
        chk("model_accepts", accepts, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
